// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory stage and its MEM/WB register.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StHold = 2'd2
    } mem_state_e;

    localparam int unsigned RegW  = 3;
    localparam int unsigned DataW = 32;
    localparam int unsigned ByteW = 8;

endpackage

// File: rtl/pipeline_MEM_WB.sv
// MEM/WB pipeline register: loads on enable, a flush turns the entry into a bubble.
module pipeline_MEM_WB
    import mem_stage_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             alu_regwrite_i,
    input  logic             mem_regwrite_i,
    input  logic [RegW-1:0]  alu_rd_i,
    input  logic [RegW-1:0]  mem_rd_i,
    input  logic [DataW-1:0] alu_out_i,
    input  logic [DataW-1:0] load_data_i,
    output logic             alu_regwrite_o,
    output logic             mem_regwrite_o,
    output logic [RegW-1:0]  alu_rd_o,
    output logic [RegW-1:0]  mem_rd_o,
    output logic [DataW-1:0] alu_out_o,
    output logic [DataW-1:0] load_data_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_regwrite_o <= 1'b0;
            mem_regwrite_o <= 1'b0;
            alu_rd_o       <= '0;
            mem_rd_o       <= '0;
            alu_out_o      <= '0;
            load_data_o    <= '0;
        end else if (en_i) begin
            // Data fields load even on a flush; only the write enables are squashed.
            alu_regwrite_o <= alu_regwrite_i & ~flush_i;
            mem_regwrite_o <= mem_regwrite_i & ~flush_i;
            alu_rd_o       <= alu_rd_i;
            mem_rd_o       <= mem_rd_i;
            alu_out_o      <= alu_out_i;
            load_data_o    <= load_data_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: byte-wide data-memory handshake with stall/timeout,
// the Z/N/C/V flag register and the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p4_pipeline_regWrite,
    input  logic             MEM_flush,
    input  logic             p3_memRead,
    input  logic             p3_memWrite,
    input  logic             p3_alu_regWrite,
    input  logic             p3_mem_regWrite,
    input  logic             p3_flag_regWrite,
    input  logic [RegW-1:0]  p3_alu_rd,
    input  logic [RegW-1:0]  p3_mem_rd,
    input  logic [ByteW-1:0] p3_mem_reg_rd,
    input  logic [DataW-1:0] p3_alu_aluOut,
    input  logic [DataW-1:0] p3_mem_address,
    input  logic             p3_flag_z,
    input  logic             p3_flag_n,
    input  logic             p3_flag_c,
    input  logic             p3_flag_v,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DataW-1:0] dmem_addr,
    output logic [ByteW-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [ByteW-1:0] dmem_rdata,
    output logic             mem_stall,
    output logic             mem_fault,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             p4_alu_regWrite,
    output logic             p4_mem_regWrite,
    output logic [RegW-1:0]  p4_alu_rd,
    output logic [RegW-1:0]  p4_mem_rd,
    output logic [DataW-1:0] p4_alu_aluOut,
    output logic [DataW-1:0] p4_mem_loadData
);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ByteW-1:0] hold_q, hold_d;
    logic             fault_q, fault_d;
    logic [3:0]       flags_q, flags_d;

    logic             access;
    logic             timeout;
    logic             complete_now;
    logic             advance;
    logic [ByteW-1:0] rdata_eff;
    logic [ByteW-1:0] load_byte;

    assign access     = p3_memRead | p3_memWrite;
    assign dmem_we    = p3_memWrite;
    assign dmem_addr  = p3_mem_address;
    assign dmem_wdata = p3_mem_reg_rd;

    assign timeout = (state_q == StBusy) && !dmem_ack && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    assign complete_now = ((state_q == StIdle) && access && dmem_ack) ||
                          ((state_q == StBusy) && (dmem_ack || timeout));
    assign mem_stall = access && !complete_now && (state_q != StHold);
    assign advance   = p4_pipeline_regWrite && !mem_stall;

    // A forced completion returns zero rather than whatever is on the bus.
    assign rdata_eff = timeout ? '0 : dmem_rdata;
    assign load_byte = (complete_now && advance) ? rdata_eff : hold_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        fault_d  = fault_q | timeout;
        flags_d  = flags_q;
        dmem_req = 1'b0;
        if (complete_now) begin
            hold_d = rdata_eff;
        end
        if (advance && p3_flag_regWrite && !MEM_flush) begin
            flags_d = {p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v};
        end
        unique case (state_q)
            StIdle: begin
                dmem_req = access;
                if (access) begin
                    if (dmem_ack) begin
                        state_d = advance ? StIdle : StHold;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = '0;
                    end
                end
            end
            StBusy: begin
                dmem_req = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (complete_now) begin
                    state_d = advance ? StIdle : StHold;
                end
            end
            StHold: begin
                // Access already done; wait for the hazard unit to let us advance.
                if (advance) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hold_q  <= '0;
            fault_q <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            fault_q <= fault_d;
            flags_q <= flags_d;
        end
    end

    assign mem_fault = fault_q;
    assign {flag_z, flag_n, flag_c, flag_v} = flags_q;

    pipeline_MEM_WB u_mem_wb (
        .clk_i          (clk),
        .rst_i          (reset),
        .en_i           (advance),
        .flush_i        (MEM_flush),
        .alu_regwrite_i (p3_alu_regWrite),
        .mem_regwrite_i (p3_mem_regWrite),
        .alu_rd_i       (p3_alu_rd),
        .mem_rd_i       (p3_mem_rd),
        .alu_out_i      (p3_alu_aluOut),
        .load_data_i    ({{(DataW - ByteW){1'b0}}, load_byte}),
        .alu_regwrite_o (p4_alu_regWrite),
        .mem_regwrite_o (p4_mem_regWrite),
        .alu_rd_o       (p4_alu_rd),
        .mem_rd_o       (p4_mem_rd),
        .alu_out_o      (p4_alu_aluOut),
        .load_data_o    (p4_mem_loadData)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB contents are queued when an
// instruction is presented and popped when it advances into MEM/WB.
module tb_mem_stage;

    typedef struct packed {
        logic        aw;
        logic        mw;
        logic [2:0]  ard;
        logic [2:0]  mrd;
        logic [31:0] alu;
        logic [31:0] ld;
    } exp_t;

    logic        clk, reset;
    logic        p4_pipeline_regWrite, MEM_flush;
    logic        p3_memRead, p3_memWrite;
    logic        p3_alu_regWrite, p3_mem_regWrite, p3_flag_regWrite;
    logic [2:0]  p3_alu_rd, p3_mem_rd;
    logic [7:0]  p3_mem_reg_rd;
    logic [31:0] p3_alu_aluOut, p3_mem_address;
    logic        p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr;
    logic [7:0]  dmem_wdata, dmem_rdata;
    logic        mem_stall, mem_fault;
    logic        flag_z, flag_n, flag_c, flag_v;
    logic        p4_alu_regWrite, p4_mem_regWrite;
    logic [2:0]  p4_alu_rd, p4_mem_rd;
    logic [31:0] p4_alu_aluOut, p4_mem_loadData;

    exp_t        p4_obs;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  last_byte;

    assign p4_obs = {p4_alu_regWrite, p4_mem_regWrite, p4_alu_rd, p4_mem_rd,
                     p4_alu_aluOut, p4_mem_loadData};

    mem_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .p4_pipeline_regWrite (p4_pipeline_regWrite),
        .MEM_flush            (MEM_flush),
        .p3_memRead           (p3_memRead),
        .p3_memWrite          (p3_memWrite),
        .p3_alu_regWrite      (p3_alu_regWrite),
        .p3_mem_regWrite      (p3_mem_regWrite),
        .p3_flag_regWrite     (p3_flag_regWrite),
        .p3_alu_rd            (p3_alu_rd),
        .p3_mem_rd            (p3_mem_rd),
        .p3_mem_reg_rd        (p3_mem_reg_rd),
        .p3_alu_aluOut        (p3_alu_aluOut),
        .p3_mem_address       (p3_mem_address),
        .p3_flag_z            (p3_flag_z),
        .p3_flag_n            (p3_flag_n),
        .p3_flag_c            (p3_flag_c),
        .p3_flag_v            (p3_flag_v),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_ack             (dmem_ack),
        .dmem_rdata           (dmem_rdata),
        .mem_stall            (mem_stall),
        .mem_fault            (mem_fault),
        .flag_z               (flag_z),
        .flag_n               (flag_n),
        .flag_c               (flag_c),
        .flag_v               (flag_v),
        .p4_alu_regWrite      (p4_alu_regWrite),
        .p4_mem_regWrite      (p4_mem_regWrite),
        .p4_alu_rd            (p4_alu_rd),
        .p4_mem_rd            (p4_mem_rd),
        .p4_alu_aluOut        (p4_alu_aluOut),
        .p4_mem_loadData      (p4_mem_loadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_p3();
        MEM_flush        = 1'b0;
        p3_memRead       = 1'b0;
        p3_memWrite      = 1'b0;
        p3_alu_regWrite  = 1'b0;
        p3_mem_regWrite  = 1'b0;
        p3_flag_regWrite = 1'b0;
        p3_alu_rd        = 3'd0;
        p3_mem_rd        = 3'd0;
        p3_mem_reg_rd    = 8'h00;
        p3_alu_aluOut    = 32'h0;
        p3_mem_address   = 32'h0;
        {p3_flag_z, p3_flag_n, p3_flag_c, p3_flag_v} = 4'b0000;
        dmem_ack         = 1'b0;
        dmem_rdata       = 8'h00;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (p4_obs !== '0) begin
            errors++;
            $display("FAIL reset_p4 got %h exp 0", p4_obs);
        end
        checks++;
        if ({dmem_req, mem_stall, mem_fault, flag_z, flag_n, flag_c, flag_v} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 0",
                     {dmem_req, mem_stall, mem_fault, flag_z, flag_n, flag_c, flag_v});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero_wait_load();
        exp_t e;
        @(negedge clk);
        clear_p3();
        p3_memRead = 1'b1; p3_mem_address = 32'h10; p3_mem_rd = 3'd3; p3_mem_regWrite = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 8'hA5; p4_pipeline_regWrite = 1'b1;
        sb.push_back('{aw: 1'b0, mw: 1'b1, ard: 3'd0, mrd: 3'd3, alu: 32'h0, ld: 32'hA5});
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL zw_stall got %b exp 0", mem_stall);
        end
        checks++;
        if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h10}) begin
            errors++;
            $display("FAIL zw_bus got %b %b %h exp 1 0 00000010", dmem_req, dmem_we, dmem_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL zw_p4 got empty scoreboard exp entry");
        end else begin
            e = sb.pop_front();
            if (p4_obs !== e) begin
                errors++;
                $display("FAIL zw_p4 got %h exp %h", p4_obs, e);
            end
        end
    endtask

    task automatic test_wait_store();
        exp_t e;
        int   req_n = 0;
        int   stall_n = 0;
        bit   bus_ok = 1'b1;
        @(negedge clk);
        clear_p3();
        p3_memWrite = 1'b1; p3_mem_reg_rd = 8'h3C; p3_mem_address = 32'h20;
        dmem_rdata = 8'h11; p4_pipeline_regWrite = 1'b1;
        sb.push_back('{aw: 1'b0, mw: 1'b0, ard: 3'd0, mrd: 3'd0, alu: 32'h0, ld: 32'h11});
        for (int c = 0; c < 4; c++) begin
            dmem_ack = (c == 3);
            #1;
            req_n   += int'(dmem_req);
            stall_n += int'(mem_stall);
            if (dmem_we !== 1'b1 || dmem_wdata !== 8'h3C || dmem_addr !== 32'h20) bus_ok = 1'b0;
            @(posedge clk);
            if (c < 3) @(negedge clk);
        end
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL ws_p4 got empty scoreboard exp entry");
        end else begin
            e = sb.pop_front();
            if (p4_obs !== e) begin
                errors++;
                $display("FAIL ws_p4 got %h exp %h", p4_obs, e);
            end
        end
        checks++;
        if (stall_n != 3) begin
            errors++;
            $display("FAIL ws_stall_cycles got %0d exp 3", stall_n);
        end
        checks++;
        if (req_n != 4) begin
            errors++;
            $display("FAIL ws_req_cycles got %0d exp 4", req_n);
        end
        checks++;
        if (!bus_ok) begin
            errors++;
            $display("FAIL ws_bus got we/wdata/addr wrong exp 1/3c/00000020");
        end
        @(negedge clk);
        clear_p3();
        #1;
        checks++;
        if (dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL ws_single got req %b exp 0", dmem_req);
        end
    endtask

    task automatic test_ext_stall();
        exp_t e;
        @(negedge clk);
        clear_p3();
        p3_alu_regWrite = 1'b1; p3_alu_rd = 3'd2; p3_alu_aluOut = 32'hCAFE0001;
        p4_pipeline_regWrite = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_p3();
        p3_memRead = 1'b1; p3_mem_regWrite = 1'b1; p3_mem_rd = 3'd5; p3_mem_address = 32'h30;
        dmem_ack = 1'b1; dmem_rdata = 8'h7F; p4_pipeline_regWrite = 1'b0;
        sb.push_back('{aw: 1'b0, mw: 1'b1, ard: 3'd0, mrd: 3'd5, alu: 32'h0, ld: 32'h7F});
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL es_stall got %b exp 0", mem_stall);
        end
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 8'h55;
        #1;
        checks++;
        if (dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL es_hold_req got %b exp 0", dmem_req);
        end
        checks++;
        if (p4_alu_aluOut !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL es_p4_hold got %h exp cafe0001", p4_alu_aluOut);
        end
        @(posedge clk);
        @(negedge clk);
        p4_pipeline_regWrite = 1'b1;
        #1;
        checks++;
        if ({dmem_req, mem_stall} !== 2'b00) begin
            errors++;
            $display("FAIL es_rel got req/stall %b exp 00", {dmem_req, mem_stall});
        end
        @(posedge clk); #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL es_p4 got empty scoreboard exp entry");
        end else begin
            e = sb.pop_front();
            if (p4_obs !== e) begin
                errors++;
                $display("FAIL es_p4 got %h exp %h", p4_obs, e);
            end
        end
        last_byte = 8'h7F;
    endtask

    task automatic test_flush_flags();
        exp_t e;
        @(negedge clk);
        clear_p3();
        p3_alu_regWrite = 1'b1; p3_alu_rd = 3'd4; p3_alu_aluOut = 32'h1234;
        p3_flag_regWrite = 1'b1; p3_flag_z = 1'b1; p3_flag_c = 1'b1;
        MEM_flush = 1'b1; p4_pipeline_regWrite = 1'b1;
        sb.push_back('{aw: 1'b0, mw: 1'b0, ard: 3'd4, mrd: 3'd0, alu: 32'h1234,
                       ld: {24'h0, last_byte}});
        @(posedge clk); #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL ff_flush_p4 got empty scoreboard exp entry");
        end else begin
            e = sb.pop_front();
            if (p4_obs !== e) begin
                errors++;
                $display("FAIL ff_flush_p4 got %h exp %h", p4_obs, e);
            end
        end
        checks++;
        if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
            errors++;
            $display("FAIL ff_flush_flags got %b exp 0000", {flag_z, flag_n, flag_c, flag_v});
        end
        @(negedge clk);
        MEM_flush = 1'b0;
        sb.push_back('{aw: 1'b1, mw: 1'b0, ard: 3'd4, mrd: 3'd0, alu: 32'h1234,
                       ld: {24'h0, last_byte}});
        @(posedge clk); #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL ff_p4 got empty scoreboard exp entry");
        end else begin
            e = sb.pop_front();
            if (p4_obs !== e) begin
                errors++;
                $display("FAIL ff_p4 got %h exp %h", p4_obs, e);
            end
        end
        checks++;
        if ({flag_z, flag_n, flag_c, flag_v} !== 4'b1010) begin
            errors++;
            $display("FAIL ff_flags got %b exp 1010", {flag_z, flag_n, flag_c, flag_v});
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clear_p3();
            p4_pipeline_regWrite = 1'b1;
            p3_alu_regWrite = 1'($urandom);
            p3_mem_regWrite = 1'($urandom);
            p3_alu_rd       = 3'($urandom);
            p3_mem_rd       = 3'($urandom);
            p3_alu_aluOut   = $urandom;
            sb.push_back('{aw: p3_alu_regWrite, mw: p3_mem_regWrite, ard: p3_alu_rd,
                           mrd: p3_mem_rd, alu: p3_alu_aluOut, ld: {24'h0, last_byte}});
            @(posedge clk); #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b_p4[%0d] got empty scoreboard exp entry", i);
            end else begin
                e = sb.pop_front();
                if (p4_obs !== e) begin
                    errors++;
                    $display("FAIL b2b_p4[%0d] got %h exp %h", i, p4_obs, e);
                end
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   stall_n = 0;
        bit   done = 1'b0;
        checks++;
        if (mem_fault !== 1'b0) begin
            errors++;
            $display("FAIL to_fault_pre got %b exp 0", mem_fault);
        end
        @(negedge clk);
        clear_p3();
        p3_memRead = 1'b1; p3_mem_regWrite = 1'b1; p3_mem_rd = 3'd6; p3_mem_address = 32'h40;
        dmem_rdata = 8'hEE; p4_pipeline_regWrite = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!mem_stall) begin
                done = 1'b1;
                break;
            end
            stall_n++;
            @(negedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL to_bound got stall still high exp release within 40 cycles");
        end
        checks++;
        if (stall_n != 15) begin
            errors++;
            $display("FAIL to_stall_cycles got %0d exp 15", stall_n);
        end
        sb.push_back('{aw: 1'b0, mw: 1'b1, ard: 3'd0, mrd: 3'd6, alu: 32'h0, ld: 32'h0});
        @(posedge clk); #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL to_p4 got empty scoreboard exp entry");
        end else begin
            e = sb.pop_front();
            if (p4_obs !== e) begin
                errors++;
                $display("FAIL to_p4 got %h exp %h", p4_obs, e);
            end
        end
        checks++;
        if (mem_fault !== 1'b1) begin
            errors++;
            $display("FAIL to_fault got %b exp 1", mem_fault);
        end
        @(negedge clk);
        clear_p3();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_fault !== 1'b1) begin
            errors++;
            $display("FAIL to_fault_sticky got %b exp 1", mem_fault);
        end
        last_byte = 8'h00;
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        @(negedge clk);
        clear_p3();
        p3_memRead = 1'b1; p3_mem_address = 32'h50; p4_pipeline_regWrite = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_p3();
        #1;
        checks++;
        if ({dmem_req, mem_stall, mem_fault} !== 3'b000) begin
            errors++;
            $display("FAIL rm_ctl got req/stall/fault %b exp 000", {dmem_req, mem_stall, mem_fault});
        end
        checks++;
        if ({flag_z, flag_n, flag_c, flag_v} !== 4'b0000) begin
            errors++;
            $display("FAIL rm_flags got %b exp 0000", {flag_z, flag_n, flag_c, flag_v});
        end
        checks++;
        if (p4_obs !== '0) begin
            errors++;
            $display("FAIL rm_p4 got %h exp 0", p4_obs);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        p3_memRead = 1'b1; p3_mem_regWrite = 1'b1; p3_mem_rd = 3'd1; p3_mem_address = 32'h60;
        dmem_ack = 1'b1; dmem_rdata = 8'h5A;
        sb.push_back('{aw: 1'b0, mw: 1'b1, ard: 3'd0, mrd: 3'd1, alu: 32'h0, ld: 32'h5A});
        #1;
        checks++;
        if ({dmem_req, mem_stall} !== 2'b10) begin
            errors++;
            $display("FAIL rm_idle got req/stall %b exp 10", {dmem_req, mem_stall});
        end
        @(posedge clk); #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL rm_p4_after got empty scoreboard exp entry");
        end else begin
            e = sb.pop_front();
            if (p4_obs !== e) begin
                errors++;
                $display("FAIL rm_p4_after got %h exp %h", p4_obs, e);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        p4_pipeline_regWrite = 1'b0;
        last_byte = 8'h00;
        clear_p3();
        test_reset();
        test_zero_wait_load();
        test_wait_store();
        test_ext_stall();
        test_flush_flags();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
